// File: rtl/i2c_touch_target.sv
// I2C target that stands in for the touch panel controller: answers pointer-write and
// register-read sequences from a small register file that the host side can preload.
module i2c_touch_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h38,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_pull,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [PTR_W-1:0] ptr,
  output logic             busy,
  output logic             rd_strobe
);

  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK, ST_PTR, ST_WDATA, ST_TX, ST_MACK, ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {NX_PTR, NX_WDATA, NX_TX} after_ack_t;

  state_t                 state;
  after_ack_t             after_ack;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic [7:0]             regs [DEPTH];
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic                   byte_done;
  logic                   bus_we;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign bus_we    = (state == ST_WDATA) && byte_done && !start_det && !stop_det;

  // Resynchronise the raw pads (idle bus is high) and keep a one-cycle-old copy for edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Register file: bus data writes first so a same-cycle host write overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (bus_we) regs[ptr] <= shift_reg;
      if (host_we) regs[host_addr] <= host_wdata;
    end
  end

  // Protocol FSM: START/STOP override bit handling; SDA only moves after an SCL fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      after_ack <= NX_PTR;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sda_pull  <= 1'b0;
      busy      <= 1'b0;
      rd_strobe <= 1'b0;
      ptr       <= '0;
    end else begin
      rd_strobe <= 1'b0;
      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_pull <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        sda_pull <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt <= '0;
              if (shift_reg[7:1] == DEV_ADDR) begin
                state     <= ST_ACK;
                sda_pull  <= 1'b1;
                busy      <= 1'b1;
                after_ack <= shift_reg[0] ? NX_TX : NX_PTR;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt   <= '0;
              state     <= ST_ACK;
              sda_pull  <= 1'b1;
              after_ack <= NX_WDATA;
              if (state == ST_PTR) ptr <= shift_reg[PTR_W-1:0];
              else                 ptr <= ptr + 1'b1;
            end
          end
          ST_ACK: begin
            if (scl_fall) begin
              bit_cnt  <= '0;
              sda_pull <= 1'b0;
              case (after_ack)
                NX_TX: begin
                  state     <= ST_TX;
                  shift_reg <= regs[ptr];
                  sda_pull  <= ~regs[ptr][7];
                  rd_strobe <= 1'b1;
                end
                NX_WDATA: state <= ST_WDATA;
                default:  state <= ST_PTR;
              endcase
            end
          end
          ST_TX: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_pull <= 1'b0;
                state    <= ST_MACK;
              end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                sda_pull  <= ~shift_reg[6];
              end
            end
          end
          ST_MACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr     <= ptr + 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                state <= ST_IGNORE;
              end
            end else if (scl_fall && (bit_cnt == 4'd9)) begin
              bit_cnt   <= '0;
              state     <= ST_TX;
              shift_reg <= regs[ptr];
              sda_pull  <= ~regs[ptr][7];
              rd_strobe <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_touch_target.sv
// Bench for i2c_touch_target: drives an open-drain I2C initiator and compares the target
// against a transaction-level model of registers, pointer, busy and SDA drive.
module tb_i2c_touch_target;

  localparam int Q      = 100;
  localparam int K_ADDR = 0;
  localparam int K_PTR  = 1;
  localparam int K_DATA = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in;
  logic       sda_in;
  logic       sda_pull;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [3:0] ptr;
  logic       busy;
  logic       rd_strobe;

  logic [7:0] m_regs [16];
  logic [3:0] m_ptr = '0;
  logic       m_busy = 1'b0;
  logic       m_pull = 1'b0;
  logic [7:0] m_tx = '0;
  int         m_strobes = 0;
  int         dut_strobes = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic       chk_en = 1'b0;
  int         quiet = 0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic [7:0] got;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_pull;

  i2c_touch_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_pull(sda_pull),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .ptr(ptr), .busy(busy), .rd_strobe(rd_strobe)
  );

  always #5 clk = ~clk;

  // Count clocks since the bus lines last moved, so checks land only on settled windows.
  always @(posedge clk) begin
    if (scl_in !== scl_prev || sda_in !== sda_prev) quiet <= 0;
    else if (quiet < 1000) quiet <= quiet + 1;
    scl_prev <= scl_in;
    sda_prev <= sda_in;
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_tx();
    m_tx = m_regs[m_ptr];
    m_pull = ~m_tx[7];
    m_strobes++;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #2;
    host_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; m_busy = 1'b0; m_pull = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; m_busy = 1'b0; m_pull = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic ack_exp, input int kind,
                            input logic collide, input logic [7:0] host_d);
    logic [3:0] c_addr;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0;
      if (i == 0) begin
        c_addr = m_ptr;
        if (ack_exp) begin
          m_pull = 1'b1;
          if (kind == K_ADDR) m_busy = 1'b1;
          else if (kind == K_PTR) m_ptr = b[3:0];
          else begin
            m_regs[m_ptr] = collide ? host_d : b;
            m_ptr++;
          end
        end
        if (collide) begin
          @(posedge clk); @(posedge clk); #2;
          host_we = 1'b1; host_addr = c_addr; host_wdata = host_d;
          @(posedge clk); #2;
          host_we = 1'b0;
          #(Q-30);
        end else begin
          #Q;
        end
      end else begin
        #Q;
      end
    end
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    check_output("ack_bit", {7'd0, sda_in}, ack_exp ? 8'd0 : 8'd1);
    #Q;
    scl_m = 1'b0;
    if (ack_exp && kind == K_ADDR && b[0]) load_tx();
    else m_pull = 1'b0;
    #Q;
  endtask

  task automatic read_byte(input logic ack, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      rd[i] = sda_in; #Q;
      scl_m = 1'b0;
      m_pull = (i > 0) ? ~m_tx[i-1] : 1'b0;
      #Q;
    end
    if (nbits == 8) begin
      sda_m = ack ? 1'b0 : 1'b1; #Q;
      scl_m = 1'b1;
      if (ack) m_ptr++;
      #(2*Q);
      scl_m = 1'b0;
      if (ack) load_tx();
      #Q;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] p);
    i2c_start();
    write_byte(8'h70, 1'b1, K_ADDR, 1'b0, 8'h00);
    write_byte({4'h0, p}, 1'b1, K_PTR, 1'b0, 8'h00);
    i2c_start();
    write_byte(8'h71, 1'b1, K_ADDR, 1'b0, 8'h00);
  endtask

  initial begin
    int w;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    fork
      forever begin
        @(negedge clk);
        if (rd_strobe) dut_strobes++;
        if (chk_en && quiet == 6 && scl_in === scl_prev && sda_in === sda_prev) begin
          check_output("model_sda_pull", {7'd0, sda_pull}, {7'd0, m_pull});
          check_output("model_busy", {7'd0, busy}, {7'd0, m_busy});
          check_output("model_ptr", {4'd0, ptr}, {4'd0, m_ptr});
        end
      end
      begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    check_output("reset_sda_pull", {7'd0, sda_pull}, 8'd0);
    check_output("reset_busy", {7'd0, busy}, 8'd0);
    check_output("reset_ptr", {4'd0, ptr}, 8'd0);
    check_output("reset_rd_strobe", {7'd0, rd_strobe}, 8'd0);
    chk_en = 1'b1;

    $display("[TB] pointer write then three-byte read");
    host_write(4'd2, 8'hA5);
    host_write(4'd3, 8'h3C);
    host_write(4'd4, 8'h0F);
    w = dut_strobes;
    apply_stimulus(4'd2);
    read_byte(1'b1, 8, got); check_output("t1_byte0", got, 8'hA5);
    read_byte(1'b1, 8, got); check_output("t1_byte1", got, 8'h3C);
    read_byte(1'b0, 8, got); check_output("t1_byte2", got, 8'h0F);
    i2c_stop();
    #Q;
    check_output("t1_ptr", {4'd0, ptr}, 8'd4);
    check_output("t1_busy", {7'd0, busy}, 8'd0);
    check_output("t1_strobes", 8'(dut_strobes - w), 8'd3);

    $display("[TB] foreign address 0x39");
    i2c_start();
    write_byte(8'h72, 1'b0, K_ADDR, 1'b0, 8'h00);
    check_output("t2_busy", {7'd0, busy}, 8'd0);
    write_byte(8'h00, 1'b0, K_DATA, 1'b0, 8'h00);
    i2c_stop();
    #Q;
    check_output("t2_ptr", {4'd0, ptr}, 8'd4);

    $display("[TB] pointer wrap on read");
    host_write(4'd15, 8'h5A);
    host_write(4'd0, 8'hC3);
    host_write(4'd1, 8'h81);
    apply_stimulus(4'd15);
    read_byte(1'b1, 8, got); check_output("t3_byte0", got, 8'h5A);
    read_byte(1'b1, 8, got); check_output("t3_byte1", got, 8'hC3);
    read_byte(1'b0, 8, got); check_output("t3_byte2", got, 8'h81);
    i2c_stop();
    #Q;
    check_output("t3_ptr", {4'd0, ptr}, 8'd1);

    $display("[TB] STOP in the middle of a transmitted byte");
    host_write(4'd8, 8'h9F);
    apply_stimulus(4'd8);
    read_byte(1'b0, 4, got);
    check_output("t4_nibble", {4'h0, got[7:4]}, 8'h09);
    i2c_stop();
    #Q;
    check_output("t4_sda_pull", {7'd0, sda_pull}, 8'd0);
    check_output("t4_busy", {7'd0, busy}, 8'd0);
    check_output("t4_ptr", {4'd0, ptr}, 8'd8);

    $display("[TB] bus writes with a colliding host write");
    i2c_start();
    write_byte(8'h70, 1'b1, K_ADDR, 1'b0, 8'h00);
    write_byte(8'h05, 1'b1, K_PTR, 1'b0, 8'h00);
    write_byte(8'h11, 1'b1, K_DATA, 1'b0, 8'h00);
    write_byte(8'h22, 1'b1, K_DATA, 1'b1, 8'h99);
    i2c_stop();
    #Q;
    check_output("t6_ptr", {4'd0, ptr}, 8'd7);
    apply_stimulus(4'd5);
    read_byte(1'b1, 8, got); check_output("t6_reg5", got, 8'h11);
    read_byte(1'b0, 8, got); check_output("t6_reg6", got, 8'h99);
    i2c_stop();

    $display("[TB] reset during an address ACK");
    i2c_start();
    b = 8'h70;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0;
      if (i > 0) #Q;
    end
    m_pull = 1'b1;
    m_busy = 1'b1;
    w = 0;
    while (sda_pull !== 1'b1 && w < 40) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk); #2;
    check_output("t5_ack_drive", {7'd0, sda_pull}, 8'd1);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check_output("t5_async_release", {7'd0, sda_pull}, 8'd0);
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_ptr = '0; m_busy = 1'b0; m_pull = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    check_output("t5_ptr", {4'd0, ptr}, 8'd0);
    check_output("t5_busy", {7'd0, busy}, 8'd0);
    i2c_stop();
    chk_en = 1'b1;
    apply_stimulus(4'd0);
    read_byte(1'b0, 8, got); check_output("t5_reg0", got, 8'h00);
    i2c_stop();
    #Q;

    check_output("strobe_total", 8'(dut_strobes), 8'(m_strobes));
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
